// File: rtl/prog_loader.sv
// prog_loader
//
// Boot-time program loader. Receives a length-prefixed byte stream from a
// host link, assembles big-endian 32-bit words and writes them sequentially
// from word address 0 into the imem/dmem syncram write port. While a load is
// in flight the processor is held via cpu_hold so it never fetches a
// partially written program.
//
// Stream format: N[15:8], N[7:0], then N words of 4 bytes each, MSB first.
//
// Handshake: a byte is consumed on a rising edge exactly when
// byte_valid && byte_ready. byte_ready depends only on registered state, so
// the host may hold byte_valid/byte_data for as long as needed. The loader
// never times out.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start              one-cycle load request (IDLE/DONE/ERROR only)
//   byte_valid/_data   host byte stream
//   byte_ready         loader accepts a byte this cycle
//   mem_address/_data  syncram write port address and word
//   mem_wren           one-cycle write strobe per word
//   cpu_hold           processor stall while loading (and after an error)
//   done, error        sticky status until the next start
//   words_written      words committed by the current or last load
//   state_dbg          current FSM state encoding for observation

module prog_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   WORDS_ONE = 1;
  localparam logic [16:0]           DEPTH_17  = 17'(DEPTH);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [1:0]  byte_idx;

  logic        xfer;
  logic [16:0] len_full;
  logic [16:0] words_after;

  assign xfer        = byte_valid && byte_ready;
  // Length as it becomes known on the LEN_LO transfer, widened so the
  // DEPTH comparison cannot overflow.
  assign len_full    = {1'b0, len_hi, byte_data};
  // Count after the word currently in WRITE commits.
  assign words_after = 17'(words_written) + 17'd1;

  // All outputs come from registered state; nothing reaches an output from
  // byte_valid, byte_data or start combinationally.
  assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
  assign mem_wren   = (state == S_WRITE);
  assign cpu_hold   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA) ||
                      (state == S_WRITE)  || (state == S_ERROR);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign state_dbg  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      len_hi        <= '0;
      len           <= '0;
      byte_idx      <= '0;
      mem_address   <= '0;
      mem_data      <= '0;
      words_written <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state         <= S_LEN_HI;
            words_written <= '0;
            mem_address   <= '0;
            byte_idx      <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= byte_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= len_full[15:0];
            if (len_full == 17'd0) begin
              state <= S_DONE;
            end else if (len_full > DEPTH_17) begin
              state <= S_ERROR;
            end else begin
              state       <= S_DATA;
              byte_idx    <= '0;
              mem_address <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            // Shift-in packs big-endian: first byte ends up in [31:24].
            mem_data <= {mem_data[23:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // The write commits on this edge. When N == DEPTH the address
          // wraps to 0 here, but the FSM leaves for DONE at the same time.
          words_written <= words_written + WORDS_ONE;
          mem_address   <= mem_address + ADDR_ONE;
          if (words_after == {1'b0, len}) begin
            state <= S_DONE;
          end else begin
            state <= S_DATA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader: the write-side counterpart of the processor's read-only instruction-memory port. It accepts a length-prefixed byte stream from a host link, assembles big-endian 32-bit instruction words, and writes them sequentially from address 0 into the imem/dmem syncram write port. While a load is in progress it holds the processor, so the processor never fetches from a partially written program.

## Interface
- ADDR_WIDTH, 12, memory word-address width (matches the 12-bit imem/dmem address).
- DEPTH, 4096, maximum number of words accepted (2**ADDR_WIDTH).
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  1-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_address  out  ADDR_WIDTH  word address for the write.
- mem_data  out  32  assembled word.
- mem_wren  out  1  write enable, one-cycle pulse per word.
- cpu_hold  out  1  processor stall/reset request while loading.
- done  out  1  load finished successfully; sticky until the next start.
- error  out  1  header length exceeded DEPTH; sticky until the next start.
- words_written  out  ADDR_WIDTH+1  number of words committed by the current or last load.

## Operation
- A byte transfer occurs on a rising edge when byte_valid && byte_ready. No other condition consumes a byte.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: byte_ready=0, cpu_hold=0. On start, go to LEN_HI, clear words_written, done and error, and set cpu_hold=1.
- LEN_HI / LEN_LO: byte_ready=1. The first transfer is the high byte of the 16-bit word count N; the second is the low byte.
- After LEN_LO:
  - N==0: go to DONE.
  - N>DEPTH: go to ERROR.
  - Otherwise: go to DATA with byte index 0 and address 0.
- DATA: byte_ready=1. Bytes are packed big-endian: the first byte goes to mem_data[31:24] and the fourth to [7:0]. The transfer of the 4th byte moves the FSM to WRITE.
- WRITE (one cycle):
  - byte_ready=0; mem_wren=1; mem_address = current index; mem_data = assembled word.
  - Next edge: increment words_written and the address.
  - If words_written reaches N, go to DONE; otherwise return to DATA.
- DONE: done=1, cpu_hold=0, byte_ready=0. start restarts the load (goes to LEN_HI).
- ERROR: error=1, cpu_hold=1, byte_ready=0, no memory writes. start restarts the load (goes to LEN_HI).
- start in LEN_HI, LEN_LO, DATA or WRITE is ignored.
- Address wrap cannot occur because N≤DEPTH. When N==DEPTH, the last write is at address DEPTH-1.
- Reset during any state aborts immediately: the FSM returns to IDLE and all outputs go to reset values. Words already written stay in memory; the partial word is discarded.

## Timing
- Reset values: byte_ready=0, mem_address=0, mem_data=0, mem_wren=0, cpu_hold=0, done=0, error=0, words_written=0; state IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from byte_valid, byte_data or start to any output.
- cpu_hold rises on the edge after start is sampled. It falls on the edge that enters DONE.
- Latency from the transfer of the 4th byte of a word: mem_wren is high in the next cycle and the write commits on the following edge.
- Peak throughput is 1 word per 5 cycles: 4 byte cycles plus 1 WRITE cycle. byte_ready drops for exactly the WRITE cycle.
- Minimum load of N words with byte_valid held high: 2 + 5N cycles from entering LEN_HI to entering DONE.
- byte_valid may be deasserted in any cycle; the loader waits without timeout and partial-word state is retained.

## Test plan
- Basic load: start, then stream 00 02 | 20 08 00 05 | AC 08 00 04 with byte_valid held high. Required response:
  - two mem_wren pulses: addr 0 data 0x20080005, then addr 1 data 0xAC080004;
  - done=1 and words_written=2 on cycle 12 after entering LEN_HI;
  - cpu_hold low from then on.
- Zero length: stream 00 00. Required response: DONE two cycles after LEN_HI, no mem_wren pulse, done=1.
- Oversize header: stream 10 01 (N=4097). Required response: error=1, cpu_hold stays 1, no writes, byte_ready=0. A following start returns the FSM to LEN_HI with error cleared.
- Stalled host: toggle byte_valid randomly during a 3-word load. Required response: words and addresses 0..2 identical to the unstalled run, and no byte lost or duplicated.
- Reset mid-word: assert reset after the 2nd data byte of word 1. Required response: all outputs drop immediately to reset values and no write occurs for the partial word. A fresh start/load then begins again at address 0.
- Busy start and full depth: pulse start during DATA and confirm it is ignored. Then load N=4096 and confirm the last write is at 0xFFF, words_written=4096, done=1.
